// File: rtl/matrix_dsp_sequencer.sv
// Program sequencer for the Matrix DSP microcode ROM: walks a latched program
// window, optionally repeats it, and flags valid/last alongside the ROM's registered output.
module matrix_dsp_sequencer #(
   parameter int ADDR_WIDTH   = 8,
   parameter int REPEAT_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    nReset,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   programBase,
   input  logic [ADDR_WIDTH-1:0]   programLastIdx,
   input  logic [REPEAT_WIDTH-1:0] repeatCount,
   input  logic                    abort,
   input  logic                    stall,
   output logic [ADDR_WIDTH-1:0]   romAddr,
   output logic                    romEnable,
   output logic                    instrValid,
   output logic                    instrLast,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  next_state_s;
   logic [ADDR_WIDTH-1:0]   pc_r;
   logic [ADDR_WIDTH-1:0]   idx_r;
   logic [ADDR_WIDTH-1:0]   base_r;
   logic [ADDR_WIDTH-1:0]   last_r;
   logic [REPEAT_WIDTH-1:0] rep_r;
   logic                    accept_s;
   logic                    rom_enable_s;
   logic                    at_last_s;
   logic                    final_fetch_s;
   logic                    instr_valid_r;
   logic                    instr_last_r;
   logic                    busy_r;
   logic                    done_r;

   // State register
   always_ff @(posedge clk) begin
      if (!nReset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Fetch qualification; abort suppresses the fetch in the same cycle
   always_comb begin
      accept_s     = 1'b0;
      rom_enable_s = 1'b0;
      case (state_r)
         ST_IDLE:  accept_s     = start && !abort;
         ST_RUN:   rom_enable_s = !stall && !abort;
         default:  rom_enable_s = 1'b0;
      endcase
      at_last_s     = (idx_r == last_r);
      final_fetch_s = rom_enable_s && at_last_s && (rep_r == {REPEAT_WIDTH{1'b0}});
   end

   // Next-state decode
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) next_state_s = ST_RUN;
            else          next_state_s = ST_IDLE;
         end
         ST_RUN: begin
            if (abort)              next_state_s = ST_IDLE;
            else if (final_fetch_s) next_state_s = ST_DRAIN;
            else                    next_state_s = ST_RUN;
         end
         ST_DRAIN: next_state_s = ST_IDLE;
         default:  next_state_s = ST_IDLE;
      endcase
   end

   // Program counter, index and repeat bookkeeping; parameters frozen at start
   always_ff @(posedge clk) begin
      if (!nReset) begin
         pc_r   <= {ADDR_WIDTH{1'b0}};
         idx_r  <= {ADDR_WIDTH{1'b0}};
         base_r <= {ADDR_WIDTH{1'b0}};
         last_r <= {ADDR_WIDTH{1'b0}};
         rep_r  <= {REPEAT_WIDTH{1'b0}};
      end else if (accept_s) begin
         base_r <= programBase;
         last_r <= programLastIdx;
         rep_r  <= repeatCount;
         pc_r   <= programBase;
         idx_r  <= {ADDR_WIDTH{1'b0}};
      end else if (rom_enable_s) begin
         if (!at_last_s) begin
            idx_r <= idx_r + ADDR_WIDTH'(1'b1);
            pc_r  <= pc_r + ADDR_WIDTH'(1'b1);
         end else if (rep_r != {REPEAT_WIDTH{1'b0}}) begin
            rep_r <= rep_r - REPEAT_WIDTH'(1'b1);
            idx_r <= {ADDR_WIDTH{1'b0}};
            pc_r  <= base_r;
         end
      end
   end

   // Status strobes registered to line up with the ROM's output register
   always_ff @(posedge clk) begin
      if (!nReset) begin
         instr_valid_r <= 1'b0;
         instr_last_r  <= 1'b0;
         done_r        <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         instr_valid_r <= rom_enable_s;
         instr_last_r  <= final_fetch_s;
         done_r        <= (state_r == ST_DRAIN) && !abort;
         busy_r        <= (next_state_s != ST_IDLE);
      end
   end

   assign romAddr    = pc_r;
   assign romEnable  = rom_enable_s;
   assign instrValid = instr_valid_r;
   assign instrLast  = instr_last_r;
   assign busy       = busy_r;
   assign done       = done_r;

endmodule

// File: tb/tb_matrix_dsp_sequencer.sv
// Directed bench for matrix_dsp_sequencer: per-cycle stimulus tables with
// hand-derived expected outputs, one task per scenario.
module tb_matrix_dsp_sequencer;

   logic       clk;
   logic       nReset;
   logic       start;
   logic       abort;
   logic       stall;
   logic [7:0] programBase;
   logic [7:0] programLastIdx;
   logic [7:0] repeatCount;
   logic [7:0] romAddr;
   logic       romEnable;
   logic       instrValid;
   logic       instrLast;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   matrix_dsp_sequencer #(.ADDR_WIDTH(8), .REPEAT_WIDTH(8)) dut (
      .clk(clk), .nReset(nReset), .start(start),
      .programBase(programBase), .programLastIdx(programLastIdx),
      .repeatCount(repeatCount), .abort(abort), .stall(stall),
      .romAddr(romAddr), .romEnable(romEnable), .instrValid(instrValid),
      .instrLast(instrLast), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus word: {nReset, start, abort, stall, base, lastIdx, repeat}
   function automatic logic [27:0] s(input logic nr, input logic st, input logic ab,
                                     input logic sl, input logic [7:0] b,
                                     input logic [7:0] l, input logic [7:0] r);
      return {nr, st, ab, sl, b, l, r};
   endfunction

   // Expected word: {check_addr, romEnable, instrValid, instrLast, busy, done, romAddr}
   function automatic logic [13:0] e(input logic ca, input logic en, input logic v,
                                     input logic l, input logic b, input logic d,
                                     input logic [7:0] a);
      return {ca, en, v, l, b, d, a};
   endfunction

   task automatic apply(input logic [27:0] v);
      {nReset, start, abort, stall, programBase, programLastIdx, repeatCount} = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [27:0] st [3];
      logic [13:0] ex [3];
      apply(s(1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 8'h02, 8'h00));
      tick();
      st[0] = s(1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 8'h02, 8'h00);
      st[1] = s(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      st[2] = st[1];
      for (int c = 0; c < 3; c++) ex[c] = e(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 3; c++) begin
         apply(st[c]);
         #1;
         n_checks++;
         if ({romEnable, instrValid, instrLast, busy, done} !== ex[c][12:8] ||
             (ex[c][13] && romAddr !== ex[c][7:0])) begin
            n_fail++;
            $display("FAIL reset c%0d: got en/v/l/busy/done=%b%b%b%b%b addr=%h, expected %b addr=%h",
                     c, romEnable, instrValid, instrLast, busy, done, romAddr, ex[c][12:8], ex[c][7:0]);
         end
         tick();
      end
   endtask

   task automatic test_basic();
      logic [27:0] st [8];
      logic [13:0] ex [8];
      for (int c = 0; c < 8; c++) begin
         st[c] = s(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
         ex[c] = e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      end
      st[0] = s(1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 8'h03, 8'h00);
      ex[1] = e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10);
      ex[2] = e(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
      ex[3] = e(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h12);
      ex[4] = e(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h13);
      ex[5] = e(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      ex[6] = e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      for (int c = 0; c < 8; c++) begin
         apply(st[c]);
         #1;
         n_checks++;
         if ({romEnable, instrValid, instrLast, busy, done} !== ex[c][12:8] ||
             (ex[c][13] && romAddr !== ex[c][7:0])) begin
            n_fail++;
            $display("FAIL basic c%0d: got en/v/l/busy/done=%b%b%b%b%b addr=%h, expected %b addr=%h",
                     c, romEnable, instrValid, instrLast, busy, done, romAddr, ex[c][12:8], ex[c][7:0]);
         end
         tick();
      end
   endtask

   task automatic test_repeat_wrap();
      logic [27:0] st [10];
      logic [13:0] ex [10];
      logic [7:0]  seq [6];
      seq[0] = 8'hFE; seq[1] = 8'hFF; seq[2] = 8'h00;
      seq[3] = 8'hFE; seq[4] = 8'hFF; seq[5] = 8'h00;
      for (int c = 0; c < 10; c++) begin
         st[c] = s(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
         ex[c] = e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      end
      st[0] = s(1'b1, 1'b1, 1'b0, 1'b0, 8'hFE, 8'h02, 8'h01);
      for (int k = 0; k < 6; k++) ex[k+1] = e(1'b1, 1'b1, (k != 0), 1'b0, 1'b1, 1'b0, seq[k]);
      ex[7] = e(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      ex[8] = e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      for (int c = 0; c < 10; c++) begin
         apply(st[c]);
         #1;
         n_checks++;
         if ({romEnable, instrValid, instrLast, busy, done} !== ex[c][12:8] ||
             (ex[c][13] && romAddr !== ex[c][7:0])) begin
            n_fail++;
            $display("FAIL repeat_wrap c%0d: got en/v/l/busy/done=%b%b%b%b%b addr=%h, expected %b addr=%h",
                     c, romEnable, instrValid, instrLast, busy, done, romAddr, ex[c][12:8], ex[c][7:0]);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      logic [27:0] st [11];
      logic [13:0] ex [11];
      for (int c = 0; c < 11; c++) begin
         st[c] = s(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
         ex[c] = e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      end
      st[0] = s(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 8'h00);
      st[3] = s(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
      st[4] = st[3];
      ex[1] = e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      ex[2] = e(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01);
      ex[3] = e(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h02);
      ex[4] = e(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02);
      ex[5] = e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02);
      ex[6] = e(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03);
      ex[7] = e(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h04);
      ex[8] = e(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      ex[9] = e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      for (int c = 0; c < 11; c++) begin
         apply(st[c]);
         #1;
         n_checks++;
         if ({romEnable, instrValid, instrLast, busy, done} !== ex[c][12:8] ||
             (ex[c][13] && romAddr !== ex[c][7:0])) begin
            n_fail++;
            $display("FAIL stall c%0d: got en/v/l/busy/done=%b%b%b%b%b addr=%h, expected %b addr=%h",
                     c, romEnable, instrValid, instrLast, busy, done, romAddr, ex[c][12:8], ex[c][7:0]);
         end
         tick();
      end
   endtask

   task automatic test_abort();
      logic [27:0] st [11];
      logic [13:0] ex [11];
      for (int c = 0; c < 11; c++) begin
         st[c] = s(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
         ex[c] = e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      end
      st[0]  = s(1'b1, 1'b1, 1'b0, 1'b0, 8'h20, 8'h07, 8'h00);
      st[4]  = s(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      st[6]  = s(1'b1, 1'b1, 1'b0, 1'b0, 8'h40, 8'h01, 8'h00);
      ex[1]  = e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20);
      ex[2]  = e(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h21);
      ex[3]  = e(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
      ex[4]  = e(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      ex[7]  = e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40);
      ex[8]  = e(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h41);
      ex[9]  = e(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      ex[10] = e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      for (int c = 0; c < 11; c++) begin
         apply(st[c]);
         #1;
         n_checks++;
         if ({romEnable, instrValid, instrLast, busy, done} !== ex[c][12:8] ||
             (ex[c][13] && romAddr !== ex[c][7:0])) begin
            n_fail++;
            $display("FAIL abort c%0d: got en/v/l/busy/done=%b%b%b%b%b addr=%h, expected %b addr=%h",
                     c, romEnable, instrValid, instrLast, busy, done, romAddr, ex[c][12:8], ex[c][7:0]);
         end
         tick();
      end
   endtask

   task automatic test_start_ignored();
      logic [27:0] st [9];
      logic [13:0] ex [9];
      for (int c = 0; c < 9; c++) begin
         st[c] = s(1'b1, 1'b0, 1'b0, 1'b0, 8'h90, 8'h00, 8'h03);
         ex[c] = e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      end
      st[0] = s(1'b1, 1'b1, 1'b0, 1'b0, 8'h50, 8'h02, 8'h00);
      st[1] = s(1'b1, 1'b0, 1'b0, 1'b0, 8'h50, 8'h02, 8'h00);
      st[2] = s(1'b1, 1'b1, 1'b0, 1'b0, 8'h90, 8'h00, 8'h03);
      st[6] = s(1'b1, 1'b1, 1'b1, 1'b0, 8'h70, 8'h01, 8'h00);
      ex[1] = e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h50);
      ex[2] = e(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h51);
      ex[3] = e(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h52);
      ex[4] = e(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      ex[5] = e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      for (int c = 0; c < 9; c++) begin
         apply(st[c]);
         #1;
         n_checks++;
         if ({romEnable, instrValid, instrLast, busy, done} !== ex[c][12:8] ||
             (ex[c][13] && romAddr !== ex[c][7:0])) begin
            n_fail++;
            $display("FAIL start_ignored c%0d: got en/v/l/busy/done=%b%b%b%b%b addr=%h, expected %b addr=%h",
                     c, romEnable, instrValid, instrLast, busy, done, romAddr, ex[c][12:8], ex[c][7:0]);
         end
         tick();
      end
   endtask

   task automatic test_reset_midrun_single();
      logic [27:0] st [11];
      logic [13:0] ex [11];
      for (int c = 0; c < 11; c++) begin
         st[c] = s(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
         ex[c] = e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      end
      st[0]  = s(1'b1, 1'b1, 1'b0, 1'b0, 8'h30, 8'h05, 8'h00);
      st[2]  = s(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
      st[3]  = s(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
      st[6]  = s(1'b1, 1'b1, 1'b0, 1'b0, 8'h88, 8'h00, 8'h00);
      ex[1]  = e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30);
      ex[2]  = e(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h31);
      ex[3]  = e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      ex[4]  = e(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      ex[7]  = e(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h88);
      ex[8]  = e(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      ex[9]  = e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      for (int c = 0; c < 11; c++) begin
         apply(st[c]);
         #1;
         n_checks++;
         if ({romEnable, instrValid, instrLast, busy, done} !== ex[c][12:8] ||
             (ex[c][13] && romAddr !== ex[c][7:0])) begin
            n_fail++;
            $display("FAIL reset_midrun_single c%0d: got en/v/l/busy/done=%b%b%b%b%b addr=%h, expected %b addr=%h",
                     c, romEnable, instrValid, instrLast, busy, done, romAddr, ex[c][12:8], ex[c][7:0]);
         end
         tick();
      end
   endtask

   // Full 256-word program from base 0x05: fetch 256 ends at 0x04 after wrapping
   task automatic test_full_rom();
      int         en_cnt = 0;
      int         v_cnt = 0;
      int         l_cnt = 0;
      int         b_cnt = 0;
      int         done_cyc = -1;
      logic [7:0] last_addr = 8'h00;
      apply(s(1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 8'hFF, 8'h00));
      tick();
      apply(s(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
      for (int c = 1; c <= 300; c++) begin
         #1;
         if (romEnable) begin
            en_cnt++;
            last_addr = romAddr;
         end
         if (instrValid) v_cnt++;
         if (instrLast) l_cnt++;
         if (busy) b_cnt++;
         if (done && done_cyc < 0) done_cyc = c;
         tick();
      end
      n_checks++;
      if (en_cnt !== 256) begin
         n_fail++;
         $display("FAIL full_rom fetches: got %0d expected 256", en_cnt);
      end
      n_checks++;
      if (v_cnt !== 256) begin
         n_fail++;
         $display("FAIL full_rom valids: got %0d expected 256", v_cnt);
      end
      n_checks++;
      if (l_cnt !== 1) begin
         n_fail++;
         $display("FAIL full_rom lasts: got %0d expected 1", l_cnt);
      end
      n_checks++;
      if (b_cnt !== 257) begin
         n_fail++;
         $display("FAIL full_rom busy cycles: got %0d expected 257", b_cnt);
      end
      n_checks++;
      if (done_cyc !== 258) begin
         n_fail++;
         $display("FAIL full_rom done cycle: got %0d expected 258", done_cyc);
      end
      n_checks++;
      if (last_addr !== 8'h04) begin
         n_fail++;
         $display("FAIL full_rom final addr: got %h expected 04", last_addr);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_repeat_wrap();
      test_stall();
      test_abort();
      test_start_ignored();
      test_reset_midrun_single();
      test_full_rom();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
